// File: rtl/rename_ctrl_pkg.sv
// Shared types and widths for the rename dispatch controller.
// Contents: register address width, free-count width, the ARCH_REG
// dispatch payload and the controller state encoding.
package rename_ctrl_pkg;

    localparam int unsigned REG_ADDR_LEN = 5;
    localparam int unsigned FREE_CNT_W   = 6;

    // Architectural operands of one decoded instruction
    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [REG_ADDR_LEN-1:0] dest;
    } ARCH_REG;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } rename_ctrl_state_e;

endpackage

// File: rtl/rename_ctrl_commit_ret_fifo.sv
// commit_ret_fifo: 2-write / 1-read FIFO of physical register numbers.
// Ports:
//   clk, reset      clock, async active-high reset
//   wr_en[1:0]      per-lane write; lane 0 lands before lane 1
//   wr_data[1:0]    per-lane physical register
//   rd_en           pop the head (ignored when empty)
//   rd_data         head entry (undefined when empty)
//   empty, count    occupancy
// The caller must not write more entries than there are free slots.
module commit_ret_fifo
    import rename_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   wr_en,
    input  logic [1:0][REG_ADDR_LEN-1:0] wr_data,
    input  logic                         rd_en,
    output logic [REG_ADDR_LEN-1:0]      rd_data,
    output logic                         empty,
    output logic [CNT_W-1:0]             count
);

    logic [REG_ADDR_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr_lane1;
    logic                    do_pop;

    assign empty        = (count == '0);
    assign do_pop       = rd_en && !empty;
    assign rd_data      = mem[rd_ptr];
    // Lane 1 goes one slot further only if lane 0 also writes
    assign wr_ptr_lane1 = wr_ptr + PTR_W'(wr_en[0]);

    // Storage is not reset; the consumer only looks at it when non-empty
    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[wr_ptr]       <= wr_data[0];
        if (wr_en[1]) mem[wr_ptr_lane1] <= wr_data[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_en[0]) + PTR_W'(wr_en[1]);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + CNT_W'(wr_en[0]) + CNT_W'(wr_en[1]) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rename_ctrl.sv
// rename_ctrl: dispatch-side controller for the register renamer.
// Gates dispatch on free physical registers, merges two commit ports into
// the renamer's single return port via commit_ret_fifo, sequences flush drain.
// Ports:
//   clk, reset                 clock, async active-high reset
//   disp_valid/disp_arch       decoded instruction in; disp_ready accepts
//   cm_valid/cm_phys           two commit-return ports; cm_ready = 2 free slots
//   flush                      single-cycle mispredict flush
//   rn_assign_flag/rn_arch_reg registered dispatch to renamer, rs_valid alongside
//   rn_return_flag/rn_commit_phys_reg  FIFO head to renamer return port
//   free_cnt, err_overflow     free register count, sticky over-return flag
// Optional: define RENAME_CTRL_PERF_EN to add perf_stall_cyc / perf_disp_cnt.
module rename_ctrl
    import rename_ctrl_pkg::*;
#(
    parameter int unsigned FREE_INIT     = 31,
    parameter int unsigned CM_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         disp_valid,
    input  ARCH_REG                      disp_arch,
    output logic                         disp_ready,
    input  logic [1:0]                   cm_valid,
    input  logic [1:0][REG_ADDR_LEN-1:0] cm_phys,
    output logic                         cm_ready,
    input  logic                         flush,
    output logic                         rn_assign_flag,
    output logic                         rn_return_flag,
    output ARCH_REG                      rn_arch_reg,
    output logic [REG_ADDR_LEN-1:0]      rn_commit_phys_reg,
    output logic                         rs_valid,
    output logic [FREE_CNT_W-1:0]        free_cnt,
    output logic                         err_overflow
`ifdef RENAME_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cyc,
    output logic [31:0]                  perf_disp_cnt
`endif
);

    localparam int unsigned FIFO_CNT_W = $clog2(CM_FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W      = FREE_CNT_W + 1;

    rename_ctrl_state_e state;
    rename_ctrl_state_e state_nxt;

    logic                    needs_dest;
    logic                    accept;
    logic                    alloc;
    logic                    pop;
    logic                    overflow;
    logic [1:0]              cm_wr_en;
    logic                    fifo_empty;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic [REG_ADDR_LEN-1:0] fifo_head;
    logic [SUM_W-1:0]        free_sum;
    logic [FREE_CNT_W-1:0]   free_nxt;

    commit_ret_fifo #(.DEPTH(CM_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cm_wr_en),
        .wr_data (cm_phys),
        .rd_en   (1'b1),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Handshakes and free-count arithmetic; STALL implies free_cnt==0,
    // so only dest-writing instructions are held there
    always_comb begin
        needs_dest         = (disp_arch.dest != '0);
        disp_ready         = (state != DRAIN) && !flush && (!needs_dest || free_cnt != '0);
        accept             = disp_valid && disp_ready;
        alloc              = accept && needs_dest;
        pop                = !fifo_empty;
        cm_ready           = (fifo_count <= FIFO_CNT_W'(CM_FIFO_DEPTH - 2));
        cm_wr_en           = cm_ready ? cm_valid : 2'b00;
        rn_return_flag     = pop;
        rn_commit_phys_reg = fifo_empty ? '0 : fifo_head;
        free_sum           = SUM_W'(free_cnt) - SUM_W'(alloc) + SUM_W'(pop);
        overflow           = (free_sum > SUM_W'(FREE_INIT));
        free_nxt           = overflow ? FREE_CNT_W'(FREE_INIT) : free_sum[FREE_CNT_W-1:0];
    end

    // Next state; flush wins over everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = DRAIN;
        end else begin
            case (state)
                RUN:     if (free_nxt == '0) state_nxt = STALL;
                STALL:   if (free_nxt != '0) state_nxt = RUN;
                DRAIN:   if (fifo_empty && cm_valid == 2'b00) state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Registered renamer dispatch outputs and free-count bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_cnt       <= FREE_CNT_W'(FREE_INIT);
            err_overflow   <= 1'b0;
            rs_valid       <= 1'b0;
            rn_assign_flag <= 1'b0;
            rn_arch_reg    <= '0;
        end else begin
            free_cnt       <= free_nxt;
            rs_valid       <= accept;
            rn_assign_flag <= alloc;
            if (overflow) err_overflow <= 1'b1;
            if (accept)   rn_arch_reg  <= disp_arch;
        end
    end

`ifdef RENAME_CTRL_PERF_EN
    // Wrapping performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_disp_cnt  <= '0;
        end else begin
            if (disp_valid && !disp_ready) perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (accept)                    perf_disp_cnt  <= perf_disp_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed testbench for rename_ctrl with hand-computed expectations.
module tb_rename_ctrl;
    import rename_ctrl_pkg::*;

    logic                         clk;
    logic                         reset;
    logic                         disp_valid;
    ARCH_REG                      disp_arch;
    logic                         disp_ready;
    logic [1:0]                   cm_valid;
    logic [1:0][REG_ADDR_LEN-1:0] cm_phys;
    logic                         cm_ready;
    logic                         flush;
    logic                         rn_assign_flag;
    logic                         rn_return_flag;
    ARCH_REG                      rn_arch_reg;
    logic [REG_ADDR_LEN-1:0]      rn_commit_phys_reg;
    logic                         rs_valid;
    logic [FREE_CNT_W-1:0]        free_cnt;
    logic                         err_overflow;
`ifdef RENAME_CTRL_PERF_EN
    logic [31:0]                  perf_stall_cyc;
    logic [31:0]                  perf_disp_cnt;
`endif

    int n_checks;
    int n_fail;

    rename_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .disp_valid         (disp_valid),
        .disp_arch          (disp_arch),
        .disp_ready         (disp_ready),
        .cm_valid           (cm_valid),
        .cm_phys            (cm_phys),
        .cm_ready           (cm_ready),
        .flush              (flush),
        .rn_assign_flag     (rn_assign_flag),
        .rn_return_flag     (rn_return_flag),
        .rn_arch_reg        (rn_arch_reg),
        .rn_commit_phys_reg (rn_commit_phys_reg),
        .rs_valid           (rs_valid),
        .free_cnt           (free_cnt),
        .err_overflow       (err_overflow)
`ifdef RENAME_CTRL_PERF_EN
        ,
        .perf_stall_cyc     (perf_stall_cyc),
        .perf_disp_cnt      (perf_disp_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ARCH_REG mk(input int s1, input int s2, input int d);
        ARCH_REG a;
        a.src1 = REG_ADDR_LEN'(s1);
        a.src2 = REG_ADDR_LEN'(s2);
        a.dest = REG_ADDR_LEN'(d);
        return a;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int s1, input int s2, input int d);
        disp_valid = 1'b1;
        disp_arch  = mk(s1, s2, d);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        disp_valid = 1'b0;
        disp_arch  = '0;
        cm_valid   = 2'b00;
        cm_phys    = '0;
        flush      = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset values
        check("rst_assign", 32'(rn_assign_flag), 0);
        check("rst_return", 32'(rn_return_flag), 0);
        check("rst_rs_valid", 32'(rs_valid), 0);
        check("rst_commit", 32'(rn_commit_phys_reg), 0);
        check("rst_cm_ready", 32'(cm_ready), 1);
        check("rst_free", 32'(free_cnt), 31);
        check("rst_err", 32'(err_overflow), 0);

        // Three back-to-back dispatches
        dispatch(0, 0, 1);
        #1 check("bb_ready0", 32'(disp_ready), 1);
        step();
        check("bb_assign0", 32'(rn_assign_flag), 1);
        check("bb_rs0", 32'(rs_valid), 1);
        check("bb_arch0", 32'(rn_arch_reg), 32'(mk(0, 0, 1)));
        check("bb_free0", 32'(free_cnt), 30);
        dispatch(0, 1, 2);
        #1 check("bb_ready1", 32'(disp_ready), 1);
        step();
        check("bb_assign1", 32'(rn_assign_flag), 1);
        check("bb_arch1", 32'(rn_arch_reg), 32'(mk(0, 1, 2)));
        check("bb_free1", 32'(free_cnt), 29);
        dispatch(1, 2, 3);
        #1 check("bb_ready2", 32'(disp_ready), 1);
        step();
        check("bb_assign2", 32'(rn_assign_flag), 1);
        check("bb_arch2", 32'(rn_arch_reg), 32'(mk(1, 2, 3)));
        check("bb_free2", 32'(free_cnt), 28);
        disp_valid = 1'b0;
        step();
        check("bb_assign_drop", 32'(rn_assign_flag), 0);
        check("bb_rs_drop", 32'(rs_valid), 0);

        // Consume down to one free register
        for (int i = 0; i < 27; i++) begin
            dispatch(0, 0, 1);
            step();
        end
        check("low_free", 32'(free_cnt), 1);

        // Last register goes, then stall for dest, pass for x0
        dispatch(0, 0, 4);
        #1 check("last_ready", 32'(disp_ready), 1);
        step();
        check("last_assign", 32'(rn_assign_flag), 1);
        check("last_free", 32'(free_cnt), 0);
        dispatch(0, 0, 5);
        #1 check("stall_ready", 32'(disp_ready), 0);
        step();
        check("stall_rs", 32'(rs_valid), 0);
        check("stall_assign", 32'(rn_assign_flag), 0);
        dispatch(3, 4, 0);
        #1 check("x0_ready", 32'(disp_ready), 1);
        step();
        check("x0_rs", 32'(rs_valid), 1);
        check("x0_assign", 32'(rn_assign_flag), 0);
        check("x0_arch", 32'(rn_arch_reg), 32'(mk(3, 4, 0)));
        check("x0_free", 32'(free_cnt), 0);
        disp_valid = 1'b0;

        // Dual commit {3,4}
        cm_valid   = 2'b11;
        cm_phys[0] = 5'd3;
        cm_phys[1] = 5'd4;
        #1 check("dual_cm_ready", 32'(cm_ready), 1);
        step();
        cm_valid = 2'b00;
        check("dual_ret0", 32'(rn_return_flag), 1);
        check("dual_phys0", 32'(rn_commit_phys_reg), 3);
        check("dual_cm_ready2", 32'(cm_ready), 1);
        check("dual_free0", 32'(free_cnt), 0);
        step();
        check("dual_phys1", 32'(rn_commit_phys_reg), 4);
        check("dual_free1", 32'(free_cnt), 1);
        step();
        check("dual_ret_end", 32'(rn_return_flag), 0);
        check("dual_free2", 32'(free_cnt), 2);

        // Alloc and pop on the same edge
        cm_valid   = 2'b11;
        cm_phys[0] = 5'd7;
        cm_phys[1] = 5'd8;
        step();
        cm_valid = 2'b00;
        dispatch(0, 0, 6);
        step();
        disp_valid = 1'b0;
        check("ap_free", 32'(free_cnt), 2);
        check("ap_assign", 32'(rn_assign_flag), 1);
        check("ap_return", 32'(rn_return_flag), 1);
        check("ap_phys", 32'(rn_commit_phys_reg), 8);
        step();
        check("ap_free2", 32'(free_cnt), 3);

        // Flush with three entries pending
        cm_valid   = 2'b11;
        cm_phys[0] = 5'd9;
        cm_phys[1] = 5'd10;
        step();
        cm_phys[0] = 5'd11;
        cm_phys[1] = 5'd12;
        flush      = 1'b1;
        dispatch(0, 0, 1);
        #1 check("fl_ready_flush", 32'(disp_ready), 0);
        check("fl_cm_ready", 32'(cm_ready), 1);
        step();
        cm_valid = 2'b00;
        flush    = 1'b0;
        check("fl_head", 32'(rn_commit_phys_reg), 10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fl_drain%0d", i), 32'(disp_ready), 0);
            step();
        end
        check("fl_exit_ready", 32'(disp_ready), 1);
        check("fl_free", 32'(free_cnt), 7);
        disp_valid = 1'b0;

        // Commit arriving mid-drain extends it
        flush      = 1'b1;
        cm_valid   = 2'b01;
        cm_phys[0] = 5'd13;
        step();
        flush    = 1'b0;
        cm_valid = 2'b00;
        check("md_drain0", 32'(disp_ready), 0);
        step();
        cm_valid   = 2'b01;
        cm_phys[0] = 5'd14;
        #1 check("md_drain1", 32'(disp_ready), 0);
        step();
        cm_valid = 2'b00;
        check("md_drain2", 32'(disp_ready), 0);
        step();
        check("md_drain3", 32'(disp_ready), 0);
        step();
        check("md_exit", 32'(disp_ready), 1);
        check("md_free", 32'(free_cnt), 9);

        // Fill back to the limit, then one return too many
        cm_valid   = 2'b01;
        cm_phys[0] = 5'd20;
        for (int i = 0; i < 22; i++) step();
        cm_valid = 2'b00;
        step();
        check("ov_full", 32'(free_cnt), 31);
        check("ov_err0", 32'(err_overflow), 0);
        cm_valid = 2'b01;
        step();
        cm_valid = 2'b00;
        step();
        check("ov_free_sat", 32'(free_cnt), 31);
        check("ov_err1", 32'(err_overflow), 1);
        step();
        check("ov_sticky", 32'(err_overflow), 1);

        // Asynchronous reset mid-stream
        dispatch(0, 0, 2);
        cm_valid   = 2'b11;
        cm_phys[0] = 5'd5;
        cm_phys[1] = 5'd6;
        step();
        cm_valid = 2'b00;
        check("pre_rst_return", 32'(rn_return_flag), 1);
        #2 reset = 1'b1;
        #1;
        check("ar_rs", 32'(rs_valid), 0);
        check("ar_assign", 32'(rn_assign_flag), 0);
        check("ar_return", 32'(rn_return_flag), 0);
        check("ar_phys", 32'(rn_commit_phys_reg), 0);
        check("ar_free", 32'(free_cnt), 31);
        check("ar_err", 32'(err_overflow), 0);
        check("ar_cm_ready", 32'(cm_ready), 1);
        check("ar_disp_ready", 32'(disp_ready), 1);
        disp_valid = 1'b0;
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
